// File: rtl/sort_frame_tx.sv
// Transmit framer: buffers sorter result words, then serializes them as
// HDR, count, little-endian word bytes and an XOR checksum for uart_tx.
module sort_frame_tx #(
    parameter int          WIDTH = 32,
    parameter int          DEPTH = 16,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_valid_i,
    input  logic             word_last_i,
    output logic             word_ready_o,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    localparam int NB = WIDTH / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        FILL,
        SEND_HDR,
        SEND_CNT,
        SEND_DATA,
        SEND_CSUM
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q;
    logic [AW-1:0]                widx_q;
    logic [BW-1:0]                bidx_q;
    logic [7:0]                   csum_q;
    logic [DEPTH-1:0][WIDTH-1:0]  word_buf;

    logic             accept;
    logic             out_hs;
    logic             last_byte;
    logic [WIDTH-1:0] cur_word;
    logic [WIDTH-1:0] cur_shift;
    logic [7:0]       cur_byte;

    assign accept    = word_valid_i && word_ready_o;
    assign out_hs    = valid_o && ready_i;
    assign cur_word  = word_buf[widx_q];
    assign cur_shift = cur_word >> {bidx_q, 3'b000};
    assign cur_byte  = cur_shift[7:0];
    assign last_byte = (bidx_q == BW'(NB - 1)) && ({1'b0, widx_q} == cnt_q - CW'(1));

    // Payload storage carries no reset; cnt alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_buf[cnt_q[AW-1:0]] <= word_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FILL;
            cnt_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (out_hs) begin
                case (state_q)
                    SEND_CNT: csum_q <= 8'(cnt_q);
                    SEND_DATA: begin
                        csum_q <= csum_q ^ cur_byte;
                        if (bidx_q == BW'(NB - 1)) begin
                            bidx_q <= '0;
                            widx_q <= widx_q + AW'(1);
                        end else begin
                            bidx_q <= bidx_q + BW'(1);
                        end
                    end
                    SEND_CSUM: begin
                        cnt_q  <= '0;
                        widx_q <= '0;
                        bidx_q <= '0;
                        csum_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        word_ready_o = 1'b0;
        valid_o      = 1'b0;
        data_o       = 8'h00;
        busy_o       = (state_q != FILL);
        case (state_q)
            FILL: begin
                word_ready_o = rst_ni && (cnt_q < CW'(DEPTH));
                if (accept && (word_last_i || cnt_q == CW'(DEPTH - 1))) begin
                    state_d = SEND_HDR;
                end
            end
            SEND_HDR: begin
                valid_o = 1'b1;
                data_o  = HDR;
                if (ready_i) state_d = SEND_CNT;
            end
            SEND_CNT: begin
                valid_o = 1'b1;
                data_o  = 8'(cnt_q);
                if (ready_i) state_d = SEND_DATA;
            end
            SEND_DATA: begin
                valid_o = 1'b1;
                data_o  = cur_byte;
                if (ready_i && last_byte) state_d = SEND_CSUM;
            end
            SEND_CSUM: begin
                valid_o = 1'b1;
                data_o  = csum_q;
                if (ready_i) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

endmodule

// File: doc/sort_frame_tx.md
# sort_frame_tx

Outbound framing block for the host link: buffers result words from the sorter and serializes them into a byte stream for `uart_tx`. This is the transmit-direction counterpart of the byte receive path. Each frame is a header byte, a word count, the words as little-endian bytes, and an XOR checksum. It sits between the sorter output and the `uart_tx` byte valid/ready port.

## Interface
Parameters:
- `WIDTH`, 32: result word width in bits. Must be a multiple of 8, range 8..64.
- `DEPTH`, 16: maximum words per frame and word-buffer size. Power of two, range 2..128.
- `HDR`, 8'hA5: frame start byte.

Ports:
- `clk_i` input 1: single clock; all logic is in this domain.
- `rst_ni` input 1: synchronous, active-low reset.
- `word_i` input WIDTH: result word from the sorter.
- `word_valid_i` input 1: `word_i` is valid.
- `word_last_i` input 1: marks the final word of a frame; qualified by `word_valid_i`.
- `word_ready_o` output 1: block accepts a word this cycle.
- `data_o` output 8: byte to `uart_tx`.
- `valid_o` output 1: `data_o` is valid; connects to `uart_tx` `valid_i`.
- `ready_i` input 1: `uart_tx` ready; connects to `uart_tx` `ready_o`.
- `busy_o` output 1: a frame is being emitted.

## Operation
- **States:** FILL, SEND_HDR, SEND_CNT, SEND_DATA, SEND_CSUM.
- **FILL**
  - `word_ready_o` = 1 while `cnt < DEPTH`.
  - A word is accepted on `word_valid_i && word_ready_o`. The word is stored at `buf[cnt]` and `cnt` increments.
  - The frame closes when an accepted word has `word_last_i` = 1, or when that acceptance makes `cnt == DEPTH`. The state then moves to SEND_HDR.
- **SEND_HDR:** `data_o` = HDR.
- **SEND_CNT:** `data_o` = `cnt`, zero-extended to 8 bits (range 1..DEPTH). The checksum register is loaded with `cnt`.
- **SEND_DATA**
  - Emits `buf[widx]` byte `bidx`, least-significant byte first, for `bidx` = 0..WIDTH/8-1, then increments `widx`.
  - Each emitted byte is XORed into the checksum.
  - The state leaves after the last byte of word `cnt-1`.
- **SEND_CSUM:** `data_o` = checksum, i.e. `cnt` XOR every data byte of the frame.
- **State advance:** every SEND_* state advances only on `valid_o && ready_i`.
- **End of frame:** on the checksum handshake, `cnt`, `widx`, `bidx` and the checksum clear, and the state returns to FILL.
- **During SEND_*:** `word_ready_o` = 0. Words presented in these states are neither consumed nor lost, because the source holds them.
- **Empty frames:** none exist. A frame is opened only by an accepted word.
- **Outputs:**
  - `valid_o` = 1 in every SEND_* state and 0 in FILL.
  - `busy_o` = (state != FILL).

## Timing
- **Reset values:** while `rst_ni` = 0 at a clock edge, the next state is FILL and `cnt`/`widx`/`bidx`/checksum are 0. Output values during and after reset:
  - `valid_o` = 0.
  - `busy_o` = 0.
  - `data_o` = 8'h00.
  - `word_ready_o` = 0 while `rst_ni` is low, and 1 from the first cycle after release.
- **Reset mid-frame:** reset in any state aborts the frame. Buffered words are discarded, and `valid_o` drops at the clocked reset edge.
- **Latency to first byte:** the edge that accepts the closing word enters SEND_HDR, so `valid_o` = 1 with HDR in the following cycle.
- **Throughput:** with `ready_i` held at 1, one byte per cycle, no bubbles. Frame length is 3 + `cnt`·WIDTH/8 bytes.
- **Backpressure:** while `valid_o && !ready_i`, `data_o` and the state are held stable. `valid_o` never drops before its handshake.
- **Return to FILL:** the cycle after the checksum handshake, `word_ready_o` = 1 and `valid_o` = 0.
- **No overlap:** input and output are never active in the same cycle. There is no dedicated `word_last_i`/DEPTH collision case: the frame closes on that word either way.
- **Implementation:** `data_o` is combinational from state and registers (mux of HDR/`cnt`/`buf`/checksum). All state is registered on `clk_i`.

## Test plan
All cases use WIDTH=32, DEPTH=4.
1. **Single word:** word 0x11223344 with last=1, `ready_i`=1 → bytes A5, 01, 44, 33, 22, 11, 45 on consecutive cycles. `valid_o` rises the cycle after acceptance. `busy_o` falls after the 7th byte.
2. **Auto-close:** 4 words 0x00000001..0x00000004, all last=0 → frame closes on the 4th acceptance with count byte 04, then 16 data bytes, then checksum 04^01^02^03^04 = 0x00. `word_ready_o` = 0 throughout the frame.
3. **Backpressure:** single-word frame with `ready_i` toggled 0/1 pseudo-randomly → the byte sequence is identical to case 1, and `data_o` is stable across every `valid_o && !ready_i` cycle.
4. **Input during send:** `word_valid_i` held at 1 with 0xDEADBEEF during SEND_DATA → not accepted. The word is accepted the first cycle after the prior frame's checksum handshake and becomes word 0 of the next frame.
5. **Reset mid-frame:** assert `rst_ni` = 0 for 1 cycle during SEND_DATA of a 2-word frame → `valid_o` = 0 and `word_ready_o` = 0 during reset. The next frame (word 0x000000AA, last=1) emits A5, 01, AA, 00, 00, 00, AB.
6. **Back-to-back frames:** two single-word frames with `ready_i` = 1 → exactly one FILL cycle with `valid_o` = 0 between the checksum byte of frame 1 and HDR of frame 2, given the word is presented immediately.
